// File: rtl/multiport_arb_pkg.sv
// Shared constants for the two-requester split arbiter: response buffer states
// and requester identifiers.
package multiport_arb_pkg;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/multiport_word_split.sv
// Combinational field splitter: low bit to c, remaining high bits to d.
module multiport_word_split #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] word_i,
  output logic             c_o,
  output logic [WIDTH-2:0] d_o
);

  assign c_o = word_i[0];
  assign d_o = word_i[WIDTH-1:1];

endmodule

// File: rtl/multiport_split_arbiter.sv
// Round-robin arbiter sharing one word splitter between two requesters, with a
// one-entry registered response buffer and saturating per-requester grant counters.
module multiport_split_arbiter
  import multiport_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic             rsp_c,
  output logic [WIDTH-2:0] rsp_d,
  output logic [CNT_W-1:0] grant0_cnt,
  output logic [CNT_W-1:0] grant1_cnt
);

  logic [0:0]       state_q, state_d;
  logic             rr_last_q, rr_last_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_c_q, rsp_c_d;
  logic [WIDTH-2:0] rsp_d_q, rsp_d_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic             can_accept;
  logic             grant0, grant1;
  logic             acc0, acc1, accept, pop;
  logic [WIDTH-1:0] sel_word;
  logic             split_c;
  logic [WIDTH-2:0] split_d;

  // A pop in the same cycle frees the buffer, so a new word can land without a bubble.
  assign can_accept = (state_q == ST_EMPTY) | rsp_ready;

  // On a conflict the requester that did not win last time gets the grant.
  assign grant0 = req0_valid & (~req1_valid | (rr_last_q == REQ_ID1));
  assign grant1 = req1_valid & (~req0_valid | (rr_last_q == REQ_ID0));

  assign req0_ready = can_accept & grant0;
  assign req1_ready = can_accept & grant1;

  assign acc0   = req0_valid & req0_ready;
  assign acc1   = req1_valid & req1_ready;
  assign accept = acc0 | acc1;
  assign pop    = (state_q == ST_FULL) & rsp_ready;

  assign sel_word = acc1 ? req1_data : req0_data;

  multiport_word_split #(
    .WIDTH (WIDTH)
  ) u_split (
    .word_i (sel_word),
    .c_o    (split_c),
    .d_o    (split_d)
  );

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    rsp_id_d  = rsp_id_q;
    rsp_c_d   = rsp_c_q;
    rsp_d_d   = rsp_d_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;

    if (accept) begin
      state_d   = ST_FULL;
      rr_last_d = acc1 ? REQ_ID1 : REQ_ID0;
      rsp_id_d  = acc1 ? REQ_ID1 : REQ_ID0;
      rsp_c_d   = split_c;
      rsp_d_d   = split_d;
    end else if (pop) begin
      state_d = ST_EMPTY;
    end

    if (acc0 && (cnt0_q != {CNT_W{1'b1}})) begin
      cnt0_d = cnt0_q + 1'b1;
    end
    if (acc1 && (cnt1_q != {CNT_W{1'b1}})) begin
      cnt1_d = cnt1_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      rr_last_q <= REQ_ID1;
      rsp_id_q  <= REQ_ID0;
      rsp_c_q   <= 1'b0;
      rsp_d_q   <= '0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      rsp_id_q  <= rsp_id_d;
      rsp_c_q   <= rsp_c_d;
      rsp_d_q   <= rsp_d_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
    end
  end

  assign rsp_valid  = (state_q == ST_FULL);
  assign rsp_id     = rsp_id_q;
  assign rsp_c      = rsp_c_q;
  assign rsp_d      = rsp_d_q;
  assign grant0_cnt = cnt0_q;
  assign grant1_cnt = cnt1_q;

endmodule

// File: tb/tb_multiport_split_arbiter.sv
// Self-checking bench: a reference model of the arbiter fills an expected-response
// queue on every modelled handshake and compares each held response against it.
module tb_multiport_split_arbiter;

   typedef struct {
      logic       id;
      logic       c;
      logic [6:0] d;
   } rspT;

   logic        clk;
   logic        rst_n;
   logic        req0Valid, req1Valid, rspReady;
   logic [7:0]  req0Data, req1Data;
   logic        req0Ready, req1Ready, rspValid, rspId, rspC;
   logic [6:0]  rspD;
   logic [15:0] grant0Cnt, grant1Cnt;

   logic        satValid;
   logic        satReady0, satReady1, satRspValid, satRspId, satRspC;
   logic [6:0]  satRspD;
   logic [1:0]  satCnt0, satCnt1;

   int testsRun;
   int testsFailed;
   int validCount;

   rspT expQ[$];
   logic mFull;
   logic mRrLast;
   int   mCnt0, mCnt1;

   multiport_split_arbiter #(.WIDTH(8), .CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0Valid),
      .req0_ready (req0Ready),
      .req0_data  (req0Data),
      .req1_valid (req1Valid),
      .req1_ready (req1Ready),
      .req1_data  (req1Data),
      .rsp_valid  (rspValid),
      .rsp_ready  (rspReady),
      .rsp_id     (rspId),
      .rsp_c      (rspC),
      .rsp_d      (rspD),
      .grant0_cnt (grant0Cnt),
      .grant1_cnt (grant1Cnt)
   );

   multiport_split_arbiter #(.WIDTH(8), .CNT_W(2)) dutSat (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (satValid),
      .req0_ready (satReady0),
      .req0_data  (8'h55),
      .req1_valid (1'b0),
      .req1_ready (satReady1),
      .req1_data  (8'h00),
      .rsp_valid  (satRspValid),
      .rsp_ready  (1'b1),
      .rsp_id     (satRspId),
      .rsp_c      (satRspC),
      .rsp_d      (satRspD),
      .grant0_cnt (satCnt0),
      .grant1_cnt (satCnt1)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      if (obs !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drives one cycle of stimulus just after the rising edge, then lets it settle.
   task automatic applyStimulus(input logic v0, input logic [7:0] d0,
                                input logic v1, input logic [7:0] d1,
                                input logic rdy);
      @(posedge clk);
      #1;
      req0Valid = v0;
      req0Data  = d0;
      req1Valid = v1;
      req1Data  = d1;
      rspReady  = rdy;
      #1;
   endtask

   task automatic doReset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   // Reference model evaluated mid-cycle while inputs are stable; updates model state
   // to what the following rising edge should produce.
   always @(negedge clk) begin
      logic mCanAccept, mG0, mG1;
      rspT  e;
      if (!rst_n) begin
         mFull   = 1'b0;
         mRrLast = 1'b1;
         mCnt0   = 0;
         mCnt1   = 0;
         expQ.delete();
      end else begin
         mCanAccept = !mFull || rspReady;
         mG0 = req0Valid && (!req1Valid || mRrLast);
         mG1 = req1Valid && (!req0Valid || !mRrLast);
         checkOutput("req0_ready", req0Ready, mCanAccept && mG0);
         checkOutput("req1_ready", req1Ready, mCanAccept && mG1);
         checkOutput("rsp_valid", rspValid, mFull);
         checkOutput("grant0_cnt", grant0Cnt, mCnt0);
         checkOutput("grant1_cnt", grant1Cnt, mCnt1);
         if (mFull) begin
            if (expQ.size() == 0) begin
               checkOutput("scoreboard_nonempty", 0, 1);
            end else begin
               checkOutput("rsp_id", rspId, expQ[0].id);
               checkOutput("rsp_c", rspC, expQ[0].c);
               checkOutput("rsp_d", rspD, expQ[0].d);
            end
            if (rspReady) begin
               if (expQ.size() != 0) void'(expQ.pop_front());
               mFull = 1'b0;
            end
         end
         if (mCanAccept && (mG0 || mG1)) begin
            e.id = mG1;
            e.c  = mG1 ? req1Data[0]   : req0Data[0];
            e.d  = mG1 ? req1Data[7:1] : req0Data[7:1];
            expQ.push_back(e);
            mFull   = 1'b1;
            mRrLast = mG1;
            if (mG0 && mCnt0 < 65535) mCnt0++;
            if (mG1 && mCnt1 < 65535) mCnt1++;
         end
      end
   end

   initial begin
      logic [7:0] streamWords [4];
      testsRun    = 0;
      testsFailed = 0;
      validCount  = 0;
      streamWords[0] = 8'h11;
      streamWords[1] = 8'h22;
      streamWords[2] = 8'hC3;
      streamWords[3] = 8'hFE;

      rst_n     = 1'b0;
      req0Valid = 1'b0;
      req1Valid = 1'b0;
      req0Data  = 8'h00;
      req1Data  = 8'h00;
      rspReady  = 1'b0;
      satValid  = 1'b0;

      // Reset state.
      #12;
      checkOutput("reset_rsp_valid", rspValid, 0);
      checkOutput("reset_rsp_c", rspC, 0);
      checkOutput("reset_rsp_d", rspD, 0);
      checkOutput("reset_rsp_id", rspId, 0);
      checkOutput("reset_cnt0", grant0Cnt, 0);
      checkOutput("reset_cnt1", grant1Cnt, 0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;

      // Single requester 0 word.
      applyStimulus(1, 8'hA5, 0, 8'h00, 1);
      applyStimulus(0, 8'h00, 0, 8'h00, 1);
      checkOutput("a5_valid", rspValid, 1);
      checkOutput("a5_id", rspId, 0);
      checkOutput("a5_c", rspC, 1);
      checkOutput("a5_d", rspD, 7'h52);
      checkOutput("a5_cnt0", grant0Cnt, 1);

      // Conflict alternation from a fresh reset.
      doReset();
      applyStimulus(1, 8'h01, 1, 8'h80, 1);
      applyStimulus(1, 8'h01, 1, 8'h80, 1);
      checkOutput("conf1_id", rspId, 0);
      checkOutput("conf1_c", rspC, 1);
      checkOutput("conf1_d", rspD, 7'h00);
      applyStimulus(1, 8'h01, 1, 8'h80, 1);
      checkOutput("conf2_id", rspId, 1);
      checkOutput("conf2_c", rspC, 0);
      checkOutput("conf2_d", rspD, 7'h40);
      applyStimulus(0, 8'h00, 0, 8'h00, 1);
      checkOutput("conf3_id", rspId, 0);
      applyStimulus(0, 8'h00, 0, 8'h00, 1);

      // Backpressure holds the buffer and blocks both requesters.
      applyStimulus(1, 8'h3C, 0, 8'h00, 0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 8'h77, 1, 8'h11, 0);
         checkOutput("bp_ready0", req0Ready, 0);
         checkOutput("bp_ready1", req1Ready, 0);
         checkOutput("bp_valid", rspValid, 1);
         checkOutput("bp_d", rspD, 7'h1E);
      end
      applyStimulus(1, 8'h77, 1, 8'h11, 1);
      checkOutput("bp_release_ready1", req1Ready, 1);
      applyStimulus(0, 8'h00, 0, 8'h00, 1);
      applyStimulus(0, 8'h00, 0, 8'h00, 1);

      // Back-to-back stream from requester 1.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 8'h00, 1, streamWords[i], 1);
         if (i > 0) validCount += int'(rspValid);
      end
      applyStimulus(0, 8'h00, 0, 8'h00, 1);
      validCount += int'(rspValid);
      checkOutput("stream_last_d", rspD, 7'h7F);
      checkOutput("stream_valid_cycles", validCount, 4);
      applyStimulus(0, 8'h00, 0, 8'h00, 1);
      checkOutput("stream_drained", rspValid, 0);

      // Narrow counter saturates at all-ones.
      @(posedge clk);
      #1;
      satValid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("sat_cnt_two", satCnt0, 2);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("sat_cnt_hold", satCnt0, 3);
      satValid = 1'b0;

      // Asynchronous reset while the buffer is full.
      applyStimulus(1, 8'hF0, 0, 8'h00, 0);
      applyStimulus(0, 8'h00, 0, 8'h00, 0);
      checkOutput("full_before_reset", rspValid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_valid", rspValid, 0);
      checkOutput("async_rst_d", rspD, 0);
      checkOutput("async_rst_cnt0", grant0Cnt, 0);
      checkOutput("async_rst_sat", satCnt0, 0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      applyStimulus(0, 8'h00, 0, 8'h00, 1);
      applyStimulus(0, 8'h00, 0, 8'h00, 1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
